// File: rtl/fifo_pack.sv
// Packs WD-bit words into WD*NW-bit entries for a FIFO write port, with one
// holding slot so assembly continues while the FIFO is briefly full.
module fifo_pack #(
  parameter int WD = 32,
  parameter int NW = 4
) (
  input  logic                  w_clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [WD-1:0]         data_in,
  input  logic                  flush,
  output logic                  wr_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wen,
  output logic [WD*NW-1:0]      fifo_wdat,
  output logic [$clog2(NW)-1:0] fill,
  output logic                  o_pend_flag,
  output logic                  o_ovf_flag,
  output logic [31:0]           o_pkt_cnt
);

  localparam int FW = $clog2(NW);
  localparam logic [FW-1:0] LAST = FW'(NW - 1);

  typedef enum logic {IDLE, FLUSH_WAIT} state_t;

  state_t              r_state;
  logic [FW-1:0]       r_fill;
  logic [WD*NW-1:0]    r_asm;
  logic [WD*NW-1:0]    r_wdat;
  logic                r_pend;
  logic                r_ovf;
  logic [31:0]         r_pktCnt;

  state_t              w_stateNext;
  logic [FW-1:0]       w_fillNext;
  logic [FW-1:0]       w_effFill;
  logic [WD*NW-1:0]    w_asmWr;
  logic [WD*NW-1:0]    w_asmNext;
  logic [WD*NW-1:0]    w_wdatNext;
  logic                w_wen;
  logic                w_slotFree;
  logic                w_ready;
  logic                w_accept;
  logic                w_flushAcc;
  logic                w_entryDone;
  logic                w_load;
  logic                w_ovfSet;

  always_comb begin
    w_wen       = r_pend & ~fifo_full;
    w_slotFree  = ~r_pend | w_wen;
    w_ready     = (r_state == IDLE) & ((r_fill != LAST) | w_slotFree);
    w_accept    = wr & w_ready;
    w_flushAcc  = flush & w_ready;
    w_entryDone = w_accept & (r_fill == LAST);
    w_ovfSet    = (wr & ~w_ready) | (flush & ~w_ready & (r_state == IDLE));
    w_asmWr     = r_asm;
    w_asmWr[int'(r_fill)*WD +: WD] = data_in;
    if (w_accept)
      w_effFill = w_entryDone ? '0 : r_fill + 1'b1;
    else
      w_effFill = r_fill;
  end

  // A flush arriving with a word applies to the assembly register after that word lands.
  always_comb begin
    w_stateNext = r_state;
    w_fillNext  = r_fill;
    w_asmNext   = r_asm;
    w_wdatNext  = r_wdat;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_entryDone) begin
            w_wdatNext = w_asmWr;
            w_load     = 1'b1;
            w_fillNext = '0;
            w_asmNext  = '0;
          end else begin
            w_fillNext = w_effFill;
            w_asmNext  = w_asmWr;
          end
        end
        if (w_flushAcc && (w_effFill != '0)) begin
          if (w_slotFree) begin
            w_wdatNext = w_accept ? w_asmWr : r_asm;
            w_load     = 1'b1;
            w_fillNext = '0;
            w_asmNext  = '0;
          end else begin
            w_stateNext = FLUSH_WAIT;
          end
        end
      end
      FLUSH_WAIT: begin
        if (w_slotFree) begin
          w_wdatNext  = r_asm;
          w_load      = 1'b1;
          w_fillNext  = '0;
          w_asmNext   = '0;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // A push and a fresh load in the same cycle keep the slot occupied.
  always_ff @(posedge w_clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_fill   <= '0;
      r_asm    <= '0;
      r_wdat   <= '0;
      r_pend   <= 1'b0;
      r_ovf    <= 1'b0;
      r_pktCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      r_fill  <= w_fillNext;
      r_asm   <= w_asmNext;
      r_wdat  <= w_wdatNext;
      if (w_load)
        r_pend <= 1'b1;
      else if (w_wen)
        r_pend <= 1'b0;
      if (w_ovfSet)
        r_ovf <= 1'b1;
      if (w_wen)
        r_pktCnt <= r_pktCnt + 32'd1;
    end
  end

  assign wr_ready    = w_ready;
  assign fifo_wen    = w_wen;
  assign fifo_wdat   = r_wdat;
  assign fill        = r_fill;
  assign o_pend_flag = r_pend;
  assign o_ovf_flag  = r_ovf;
  assign o_pkt_cnt   = r_pktCnt;

endmodule

// File: tb/tb_fifo_pack.sv
// Bench for fifo_pack: table of per-cycle vectors plus hand sequences for stall,
// flush-wait and reset; pushed entries are checked against a scoreboard queue.
module tb_fifo_pack;

  logic         w_clk;
  logic         rst;
  logic         wr;
  logic [31:0]  data_in;
  logic         flush;
  logic         wr_ready;
  logic         fifo_full;
  logic         fifo_wen;
  logic [127:0] fifo_wdat;
  logic [1:0]   fill;
  logic         o_pend_flag;
  logic         o_ovf_flag;
  logic [31:0]  o_pkt_cnt;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [127:0] expQ[$];

  typedef struct {
    logic         wr;
    logic [31:0]  data;
    logic         flush;
    logic         full;
    logic         expReady;
    logic [1:0]   expFill;
    logic         expPend;
    logic [31:0]  expPkt;
    logic         push;
    logic [127:0] entry;
  } vec_t;

  vec_t vecs[$];

  fifo_pack #(.WD(32), .NW(4)) dut (
    .w_clk(w_clk), .rst(rst), .wr(wr), .data_in(data_in), .flush(flush),
    .wr_ready(wr_ready), .fifo_full(fifo_full), .fifo_wen(fifo_wen),
    .fifo_wdat(fifo_wdat), .fill(fill), .o_pend_flag(o_pend_flag),
    .o_ovf_flag(o_ovf_flag), .o_pkt_cnt(o_pkt_cnt)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic iWr, input logic [31:0] iData,
                               input logic iFlush, input logic iFull);
    wr = iWr; data_in = iData; flush = iFlush; fifo_full = iFull;
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic addVec(input logic iWr, input logic [31:0] iData, input logic iFlush,
                        input logic iFull, input logic eReady, input logic [1:0] eFill,
                        input logic ePend, input logic [31:0] ePkt,
                        input logic ePush, input logic [127:0] eEntry);
    vec_t v;
    v.wr = iWr; v.data = iData; v.flush = iFlush; v.full = iFull;
    v.expReady = eReady; v.expFill = eFill; v.expPend = ePend; v.expPkt = ePkt;
    v.push = ePush; v.entry = eEntry;
    vecs.push_back(v);
  endtask

  // Every FIFO write must match the oldest outstanding expected entry.
  always @(negedge w_clk) begin
    if (!rst && fifo_wen) begin
      if (expQ.size() == 0) begin
        totalCnt++;
        $display("[TB] FAIL unexpected_wen: got wdat %0h, expected no write", fifo_wdat);
      end else begin
        checkOutput("fifo_wdat", fifo_wdat, expQ.pop_front());
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_fill", 128'(fill), 128'd0);
    checkOutput("reset_pend", 128'(o_pend_flag), 128'd0);
    checkOutput("reset_ovf", 128'(o_ovf_flag), 128'd0);
    checkOutput("reset_pkt", 128'(o_pkt_cnt), 128'd0);
    checkOutput("reset_wdat", fifo_wdat, 128'd0);
    rst = 1'b0;

    // wr data flush full | ready fill pend pkt | push entry
    addVec(1, 32'h11111111, 0, 0, 1, 1, 0, 0, 0, '0);
    addVec(1, 32'h22222222, 0, 0, 1, 2, 0, 0, 0, '0);
    addVec(1, 32'h33333333, 0, 0, 1, 3, 0, 0, 0, '0);
    addVec(1, 32'h44444444, 0, 0, 1, 0, 1, 0, 1,
           {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    addVec(0, 32'h0, 0, 0, 1, 0, 0, 1, 0, '0);
    addVec(1, 32'hA, 0, 0, 1, 1, 0, 1, 0, '0);
    addVec(1, 32'hB, 0, 0, 1, 2, 0, 1, 0, '0);
    addVec(0, 32'h0, 1, 0, 1, 0, 1, 1, 1, {32'h0, 32'h0, 32'hB, 32'hA});
    addVec(0, 32'h0, 0, 0, 1, 0, 0, 2, 0, '0);
    addVec(0, 32'h0, 1, 0, 1, 0, 0, 2, 0, '0);
    addVec(0, 32'h0, 0, 0, 1, 0, 0, 2, 0, '0);
    addVec(1, 32'hC, 1, 0, 1, 0, 1, 2, 1, {32'h0, 32'h0, 32'h0, 32'hC});
    addVec(0, 32'h0, 0, 0, 1, 0, 0, 3, 0, '0);
    addVec(1, 32'h1, 0, 0, 1, 1, 0, 3, 0, '0);
    addVec(1, 32'h2, 0, 0, 1, 2, 0, 3, 0, '0);
    addVec(1, 32'h3, 0, 0, 1, 3, 0, 3, 0, '0);
    addVec(1, 32'h4, 1, 0, 1, 0, 1, 3, 1, {32'h4, 32'h3, 32'h2, 32'h1});
    addVec(0, 32'h0, 0, 0, 1, 0, 0, 4, 0, '0);
    addVec(0, 32'h0, 0, 0, 1, 0, 0, 4, 0, '0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].flush, vecs[i].full);
      if (vecs[i].push) expQ.push_back(vecs[i].entry);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), 128'(wr_ready), 128'(vecs[i].expReady));
      tick();
      checkOutput($sformatf("vec%0d_fill", i), 128'(fill), 128'(vecs[i].expFill));
      checkOutput($sformatf("vec%0d_pend", i), 128'(o_pend_flag), 128'(vecs[i].expPend));
      checkOutput($sformatf("vec%0d_pkt", i), 128'(o_pkt_cnt), 128'(vecs[i].expPkt));
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("table_ovf", 128'(o_ovf_flag), 128'd0);

    // FIFO full: one entry held, three more words assembled, eighth word refused.
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b0, 1'b1);
      if (k == 4) expQ.push_back({32'h4, 32'h3, 32'h2, 32'h1});
      tick();
    end
    checkOutput("stall_fill", 128'(fill), 128'd3);
    checkOutput("stall_pend", 128'(o_pend_flag), 128'd1);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b1);
    #1;
    checkOutput("stall_ready", 128'(wr_ready), 128'd0);
    tick();
    checkOutput("stall_ovf", 128'(o_ovf_flag), 128'd1);
    checkOutput("stall_fill_kept", 128'(fill), 128'd3);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
    expQ.push_back({32'h8, 32'h7, 32'h6, 32'h5});
    #1;
    checkOutput("release_ready", 128'(wr_ready), 128'd1);
    tick();
    checkOutput("release_pend", 128'(o_pend_flag), 128'd1);
    checkOutput("release_pkt", 128'(o_pkt_cnt), 128'd5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("drain_pkt", 128'(o_pkt_cnt), 128'd6);
    checkOutput("drain_pend", 128'(o_pend_flag), 128'd0);

    // Reset with a held entry and a partial entry discards both.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 32'hE0 + 32'(k), 1'b0, 1'b1);
      tick();
    end
    checkOutput("prerst_fill", 128'(fill), 128'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_fill", 128'(fill), 128'd0);
    checkOutput("rst_pend", 128'(o_pend_flag), 128'd0);
    checkOutput("rst_ovf", 128'(o_ovf_flag), 128'd0);
    checkOutput("rst_pkt", 128'(o_pkt_cnt), 128'd0);
    checkOutput("rst_wdat", fifo_wdat, 128'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'hD0 + 32'(k), 1'b0, 1'b0);
      if (k == 3) expQ.push_back({32'hD3, 32'hD2, 32'hD1, 32'hD0});
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("postrst_pkt", 128'(o_pkt_cnt), 128'd1);

    // Flush while the slot is blocked waits, then emits right after the held entry.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 32'hF0 + 32'(k), 1'b0, 1'b1);
      if (k == 3) expQ.push_back({32'hF3, 32'hF2, 32'hF1, 32'hF0});
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("fwait_ready", 128'(wr_ready), 128'd0);
    checkOutput("fwait_fill", 128'(fill), 128'd2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("fwait_flush_absorbed", 128'(o_ovf_flag), 128'd0);
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b1);
    tick();
    checkOutput("fwait_wr_ovf", 128'(o_ovf_flag), 128'd1);
    checkOutput("fwait_wr_dropped", 128'(fill), 128'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    expQ.push_back({32'h0, 32'h0, 32'hF5, 32'hF4});
    tick();
    checkOutput("fwait_pend", 128'(o_pend_flag), 128'd1);
    checkOutput("fwait_pkt1", 128'(o_pkt_cnt), 128'd2);
    tick();
    checkOutput("fwait_pkt2", 128'(o_pkt_cnt), 128'd3);
    checkOutput("fwait_done_ready", 128'(wr_ready), 128'd1);
    checkOutput("fwait_done_fill", 128'(fill), 128'd0);
    tick();
    checkOutput("scoreboard_empty", 128'(expQ.size()), 128'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
